// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: arbitrates instruction fetch and data load/store onto the
// single-port data memory. Round-robin on conflict, fixed MEM_LAT access time,
// one-cycle acknowledge pulse. All outputs are registered.
module mem_port_arbiter #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 64,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              busy,
  output logic              owner
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state;
  logic [3:0] cnt;
  logic       we_q;
  logic       grant_fetch;

  // Fetch wins when it is the only requester, or on conflict when data
  // held the most recent grant.
  always_comb begin
    grant_fetch = if_req && (!d_req || owner);
  end

  // Grant, hold and complete one memory transaction at a time.
  // mem_we is set together with the grant so that it is high only during the
  // first BUSY cycle; the default clear below retires it one cycle later.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      we_q     <= 1'b0;
      mem_addr <= '0;
      mem_din  <= '0;
      rdata    <= '0;
      mem_we   <= 1'b0;
      if_ack   <= 1'b0;
      d_ack    <= 1'b0;
      busy     <= 1'b0;
      owner    <= 1'b1;
    end else begin
      mem_we <= 1'b0;
      if_ack <= 1'b0;
      d_ack  <= 1'b0;
      case (state)
        IDLE: begin
          if (if_req || d_req) begin
            if (grant_fetch) begin
              owner    <= 1'b0;
              mem_addr <= if_addr;
              we_q     <= 1'b0;
            end else begin
              owner    <= 1'b1;
              mem_addr <= d_addr;
              mem_din  <= d_wdata;
              we_q     <= d_we;
              mem_we   <= d_we;
            end
            cnt   <= 4'(MEM_LAT - 1);
            busy  <= 1'b1;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (cnt == 4'd0) begin
            if (!we_q) begin
              rdata <= mem_dout;
            end
            if_ack <= ~owner;
            d_ack  <= owner;
            state  <= DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of mem_port_arbiter with MEM_LAT=1
// (instance 0) and MEM_LAT=3 (instance 1), each backed by a simple memory.
module tb_mem_port_arbiter;

  localparam int AW = 12;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          reset   [2];
  logic          if_req  [2];
  logic [AW-1:0] if_addr [2];
  logic          if_ack  [2];
  logic          d_req   [2];
  logic          d_we    [2];
  logic [AW-1:0] d_addr  [2];
  logic [DW-1:0] d_wdata [2];
  logic          d_ack   [2];
  logic [DW-1:0] rdata   [2];
  logic [AW-1:0] mem_addr[2];
  logic          mem_we  [2];
  logic [DW-1:0] mem_din [2];
  logic [DW-1:0] mem_dout[2];
  logic          busy    [2];
  logic          owner   [2];

  logic [DW-1:0] mem0 [4096];
  logic [DW-1:0] mem1 [4096];

  typedef struct {
    bit            dat;
    logic [DW-1:0] rd;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] stored[int];
  logic [DW-1:0] last_rd[2];
  int            total = 0;
  int            bad   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1)) u_dut0 (
    .clk(clk), .reset(reset[0]),
    .if_req(if_req[0]), .if_addr(if_addr[0]), .if_ack(if_ack[0]),
    .d_req(d_req[0]), .d_we(d_we[0]), .d_addr(d_addr[0]), .d_wdata(d_wdata[0]),
    .d_ack(d_ack[0]), .rdata(rdata[0]),
    .mem_addr(mem_addr[0]), .mem_we(mem_we[0]), .mem_din(mem_din[0]),
    .mem_dout(mem_dout[0]), .busy(busy[0]), .owner(owner[0])
  );

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(3)) u_dut1 (
    .clk(clk), .reset(reset[1]),
    .if_req(if_req[1]), .if_addr(if_addr[1]), .if_ack(if_ack[1]),
    .d_req(d_req[1]), .d_we(d_we[1]), .d_addr(d_addr[1]), .d_wdata(d_wdata[1]),
    .d_ack(d_ack[1]), .rdata(rdata[1]),
    .mem_addr(mem_addr[1]), .mem_we(mem_we[1]), .mem_din(mem_din[1]),
    .mem_dout(mem_dout[1]), .busy(busy[1]), .owner(owner[1])
  );

  // Asynchronous-read, synchronous-write memories.
  assign mem_dout[0] = mem0[mem_addr[0]];
  assign mem_dout[1] = mem1[mem_addr[1]];

  always @(posedge clk) begin
    if (mem_we[0]) mem0[mem_addr[0]] <= mem_din[0];
    if (mem_we[1]) mem1[mem_addr[1]] <= mem_din[1];
  end

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    if (a == 12'h010) return 64'h13;
    return 64'hA5A5_0000_0000_0000 | {52'h0, a} | ({52'h0, a} << 32);
  endfunction

  function automatic logic [DW-1:0] ref_rd(input int k, input logic [AW-1:0] a);
    int key;
    key = k * 4096 + int'(a);
    if (stored.exists(key)) return stored[key];
    return init_val(a);
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state(input int k);
    chk("rst_mem_addr", 64'(mem_addr[k]), 64'h0);
    chk("rst_mem_din",  mem_din[k], 64'h0);
    chk("rst_rdata",    rdata[k], 64'h0);
    chk("rst_mem_we",   64'(mem_we[k]), 64'h0);
    chk("rst_if_ack",   64'(if_ack[k]), 64'h0);
    chk("rst_d_ack",    64'(d_ack[k]), 64'h0);
    chk("rst_busy",     64'(busy[k]), 64'h0);
    chk("rst_owner",    64'(owner[k]), 64'h1);
  endtask

  task automatic pop_and_check(input int k);
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_underflow", 64'(sb.size()), 64'h1);
      return;
    end
    e = sb.pop_front();
    chk("ack_kind_d",  64'(d_ack[k]), 64'(e.dat));
    chk("ack_kind_if", 64'(if_ack[k]), 64'(!e.dat));
    chk("owner",       64'(owner[k]), 64'(e.dat));
    chk("rdata",       rdata[k], e.rd);
    last_rd[k] = e.rd;
  endtask

  // One complete transaction on instance k, requester idle before and after.
  task automatic txn(input int k, input bit dat, input bit we, input logic [AW-1:0] a,
                     input logic [DW-1:0] wd, input int lat);
    exp_t e;
    int   n, wes, busies;
    bit   got;
    e.dat = dat;
    e.rd  = (dat && we) ? last_rd[k] : ref_rd(k, a);
    if (dat && we) stored[k * 4096 + int'(a)] = wd;
    sb.push_back(e);
    if (dat) begin
      d_req[k] = 1'b1; d_we[k] = we; d_addr[k] = a; d_wdata[k] = wd;
    end else begin
      if_req[k] = 1'b1; if_addr[k] = a;
      d_we[k] = 1'b1;
    end
    n = 0; wes = 0; busies = 0; got = 0;
    while (!got && n < 40) begin
      tick();
      n++;
      wes    += int'(mem_we[k]);
      busies += int'(busy[k]);
      if (if_ack[k] || d_ack[k]) got = 1;
      else chk("addr_held", 64'(mem_addr[k]), 64'(a));
    end
    if_req[k] = 1'b0; d_req[k] = 1'b0; d_we[k] = 1'b0;
    chk("ack_seen",  64'(got), 64'h1);
    chk("ack_lat",   64'(n), 64'(lat + 1));
    chk("we_pulses", 64'(wes), 64'(dat && we));
    chk("busy_cyc",  64'(busies), 64'(lat + 1));
    pop_and_check(k);
    tick();
    chk("ack_pulse", 64'(if_ack[k] | d_ack[k]), 64'h0);
    chk("busy_idle", 64'(busy[k]), 64'h0);
  endtask

  initial begin
    int   n, j;
    bit   got;
    exp_t e;

    for (int unsigned i = 0; i < 4096; i++) begin
      mem0[i] = init_val(AW'(i));
      mem1[i] = init_val(AW'(i));
    end
    for (int unsigned k = 0; k < 2; k++) begin
      reset[k] = 1'b1; if_req[k] = 1'b0; if_addr[k] = '0; d_req[k] = 1'b0;
      d_we[k] = 1'b0; d_addr[k] = '0; d_wdata[k] = '0; last_rd[k] = '0;
    end
    tick();
    tick();
    chk_reset_state(0);
    chk_reset_state(1);
    reset[0] = 1'b0;
    reset[1] = 1'b0;
    tick();

    // MEM_LAT=1: single fetch, then store and load-back.
    txn(0, 1'b0, 1'b0, 12'h010, 64'h0, 1);
    txn(0, 1'b1, 1'b1, 12'h020, 64'hDEADBEEF, 1);
    txn(0, 1'b1, 1'b0, 12'h020, 64'h0, 1);
    chk("load_back", last_rd[0], 64'hDEADBEEF);

    // Conflict straight after reset: strict alternation starting with fetch.
    reset[0] = 1'b1;
    tick();
    reset[0] = 1'b0;
    last_rd[0] = '0;
    if_req[0] = 1'b1; if_addr[0] = 12'h040;
    d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 12'h050;
    for (int i = 0; i < 6; i++) begin
      e.dat = (i % 2) == 1;
      e.rd  = e.dat ? ref_rd(0, 12'h050) : ref_rd(0, 12'h040);
      sb.push_back(e);
    end
    for (j = 0; j < 6; j++) begin
      n = 0; got = 0;
      while (!got && n < 40) begin
        tick();
        n++;
        if (if_ack[0] || d_ack[0]) got = 1;
      end
      chk("conf_ack_seen", 64'(got), 64'h1);
      if (j == 5) begin
        if_req[0] = 1'b0; d_req[0] = 1'b0;
      end
      pop_and_check(0);
    end
    tick();
    tick();

    // MEM_LAT=3: fetch with held address and longer busy window.
    txn(1, 1'b0, 1'b0, 12'h010, 64'h0, 3);

    // Late data request while a fetch is in flight.
    e.dat = 1'b0; e.rd = ref_rd(1, 12'h070); sb.push_back(e);
    if_req[1] = 1'b1; if_addr[1] = 12'h070;
    tick();
    tick();
    e.dat = 1'b1; e.rd = ref_rd(1, 12'h080); sb.push_back(e);
    d_req[1] = 1'b1; d_we[1] = 1'b0; d_addr[1] = 12'h080;
    n = 2; got = 0;
    while (!got && n < 40) begin
      tick();
      n++;
      if (if_ack[1] || d_ack[1]) got = 1;
    end
    chk("late_fetch_lat", 64'(n), 64'h4);
    if_req[1] = 1'b0;
    pop_and_check(1);
    tick();
    chk("late_idle_busy", 64'(busy[1]), 64'h0);
    n = 0; got = 0;
    while (!got && n < 40) begin
      tick();
      n++;
      if (if_ack[1] || d_ack[1]) got = 1;
    end
    chk("late_data_lat", 64'(n), 64'h4);
    d_req[1] = 1'b0;
    pop_and_check(1);
    tick();

    // Reset in the second BUSY cycle of a load: aborted, no ack.
    d_req[1] = 1'b1; d_we[1] = 1'b0; d_addr[1] = 12'h030;
    got = 0;
    tick();
    got |= if_ack[1] | d_ack[1];
    tick();
    got |= if_ack[1] | d_ack[1];
    reset[1] = 1'b1;
    tick();
    got |= if_ack[1] | d_ack[1];
    chk_reset_state(1);
    reset[1] = 1'b0;
    d_req[1] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      got |= if_ack[1] | d_ack[1];
    end
    chk("abort_no_ack", 64'(got), 64'h0);
    last_rd[1] = '0;
    txn(1, 1'b0, 1'b0, 12'h060, 64'h0, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
